// File: rtl/recv_port_arbiter.sv
// Round-robin arbiter that shares one Ethernet frame receiver among NUM_PORTS ingress ports.
// Grants a port, pulses the receiver start, tracks the frame via rx_rdy and aborts on timeout.
module recv_port_arbiter #(
    parameter int          NUM_PORTS      = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2048,
    parameter logic [3:0]  RST_CYCLES     = 4'd2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [NUM_PORTS*8-1:0]       port_data,
    input  logic                         rx_rdy,
    output logic                         rx_start,
    output logic [7:0]                   rx_data,
    output logic                         rx_rst,
    output logic [NUM_PORTS-1:0]         gnt,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         timeout_err,
    output logic [$clog2(NUM_PORTS)-1:0] cur_port
);
    localparam int                IDX_W     = $clog2(NUM_PORTS);
    localparam int                PW        = IDX_W + 1;
    localparam logic [IDX_W-1:0]  LAST_PORT = IDX_W'(NUM_PORTS - 1);
    localparam logic [PW-1:0]     PORTS_W   = PW'(NUM_PORTS);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, RECV, ABORT} state_t;

    state_t               state, state_d;
    logic [NUM_PORTS-1:0] gnt_d;
    logic [IDX_W-1:0]     cur_port_d;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [PW-1:0]        scan;
    logic [15:0]          wdog, wdog_d;
    logic [3:0]           rst_cnt, rst_cnt_d;
    logic                 frame_done_d, timeout_err_d;

    // Scan upward from the port after the last grant, wrapping at NUM_PORTS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = cur_port;
        scan      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan = {1'b0, cur_port} + PW'(k);
            if (scan >= PORTS_W) scan = scan - PORTS_W;
            if (!win_found && req[scan[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state;
        gnt_d         = gnt;
        cur_port_d    = cur_port;
        wdog_d        = wdog;
        rst_cnt_d     = rst_cnt;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_rdy && win_found) begin
                    state_d          = START;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    cur_port_d       = win_idx;
                end
            end
            START: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!rx_rdy) begin
                    state_d = RECV;
                    wdog_d  = '0;
                end else begin
                    state_d       = ABORT;
                    gnt_d         = '0;
                    rst_cnt_d     = '0;
                    timeout_err_d = 1'b1;
                end
            end
            RECV: begin
                wdog_d = wdog + 16'd1;
                // A returning rx_rdy takes priority over an expiring watchdog.
                if (rx_rdy) begin
                    state_d      = IDLE;
                    gnt_d        = '0;
                    frame_done_d = 1'b1;
                end else if (wdog == TIMEOUT_CYCLES - 16'd1) begin
                    state_d       = ABORT;
                    gnt_d         = '0;
                    rst_cnt_d     = '0;
                    timeout_err_d = 1'b1;
                end
            end
            ABORT: begin
                if (rst_cnt == RST_CYCLES - 4'd1) state_d = IDLE;
                else                              rst_cnt_d = rst_cnt + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            cur_port    <= LAST_PORT;
            wdog        <= '0;
            rst_cnt     <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_d;
            gnt         <= gnt_d;
            cur_port    <= cur_port_d;
            wdog        <= wdog_d;
            rst_cnt     <= rst_cnt_d;
            frame_done  <= frame_done_d;
            timeout_err <= timeout_err_d;
        end
    end

    assign rx_start = (state == START);
    assign rx_rst   = (state == ABORT);
    assign busy     = (state != IDLE);

    // AND-OR mux: each output bit gathers that bit from every port, masked by the one-hot grant.
    logic [7:0][NUM_PORTS-1:0] data_col;
    for (genvar b = 0; b < 8; b++) begin : g_bit
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
            assign data_col[b][g] = port_data[g*8 + b];
        end
        assign rx_data[b] = |(gnt & data_col[b]);
    end
endmodule

// File: tb/tb_recv_port_arbiter.sv
// Bench for recv_port_arbiter: vector table, hand-written corner sequences and randomized
// frames checked against a round-robin model that picks winners by modulo scanning.
module tb_recv_port_arbiter;
    localparam int NP        = 4;
    localparam int TO        = 16;
    localparam int RC        = 2;
    localparam int K_NORMAL  = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_REJECT  = 2;

    logic            clk;
    logic            rst;
    logic [NP-1:0]   req;
    logic [NP*8-1:0] port_data;
    logic            rx_rdy;
    logic            rx_start;
    logic [7:0]      rx_data;
    logic            rx_rst;
    logic [NP-1:0]   gnt;
    logic            busy;
    logic            frame_done;
    logic            timeout_err;
    logic [1:0]      cur_port;

    int n_checks;
    int n_fail;
    int m_cur;
    int p, kind, roll, len;
    logic [NP-1:0] r_rand;

    typedef struct {
        logic [NP-1:0]   req;
        logic [NP*8-1:0] pdata;
        int              exp_port;
        logic [7:0]      exp_data;
    } vec_t;

    vec_t tbl [10];
    int   fair_exp [5];

    recv_port_arbiter #(
        .NUM_PORTS      (NP),
        .TIMEOUT_CYCLES (16'(TO)),
        .RST_CYCLES     (4'(RC))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .port_data   (port_data),
        .rx_rdy      (rx_rdy),
        .rx_start    (rx_start),
        .rx_data     (rx_data),
        .rx_rst      (rx_rst),
        .gnt         (gnt),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .cur_port    (cur_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slice(input int port);
        return port_data[port*8 +: 8];
    endfunction

    // Round-robin reference: first requester scanning upward from last+1, modulo NP.
    function automatic int predict(input logic [NP-1:0] r, input int last);
        for (int k = 1; k <= NP; k++) begin
            int q;
            q = (last + k) % NP;
            if (r[q]) return q;
        end
        return -1;
    endfunction

    // One complete transaction from IDLE back to IDLE, playing the receiver side.
    task automatic do_frame(input logic [NP-1:0] r, input int fkind, input int flen,
                            input int exp_port, input logic [7:0] exp_d, input bit scramble);
        logic [NP-1:0] eg;
        int            n_low;
        bit            aborted;
        eg           = '0;
        eg[exp_port] = 1'b1;
        aborted      = (fkind == K_REJECT);
        req          = r;
        rx_rdy       = 1'b1;
        tick();
        check("start_pulse", rx_start, 1);
        check("start_gnt", gnt, eg);
        check("start_cur_port", cur_port, exp_port);
        check("start_busy", busy, 1);
        check("start_rx_data", rx_data, exp_d);
        if (fkind != K_REJECT) rx_rdy = 1'b0;
        if (scramble) begin
            req       = NP'($urandom);
            port_data = $urandom;
        end
        tick();
        check("wait_start_low", rx_start, 0);
        check("wait_gnt", gnt, eg);
        check("wait_rx_data", rx_data, slice(exp_port));
        tick();
        if (fkind != K_REJECT) begin
            n_low = (fkind == K_NORMAL) ? flen - 1 : TO - 1;
            for (int i = 0; i < n_low; i++) begin
                check("recv_gnt", gnt, eg);
                check("recv_no_done", frame_done, 0);
                check("recv_no_err", timeout_err, 0);
                check("recv_rx_data", rx_data, slice(exp_port));
                if (scramble) begin
                    req       = NP'($urandom);
                    port_data = $urandom;
                end
                tick();
            end
            check("recv_last_no_err", timeout_err, 0);
            check("recv_last_busy", busy, 1);
            check("recv_last_gnt", gnt, eg);
            check("recv_last_rx_data", rx_data, slice(exp_port));
            if (fkind == K_NORMAL) begin
                rx_rdy = 1'b1;
                tick();
                check("done_pulse", frame_done, 1);
                check("done_gnt_clear", gnt, 0);
                check("done_idle", busy, 0);
                check("done_no_err", timeout_err, 0);
                check("done_cur_port", cur_port, exp_port);
                check("done_rx_data", rx_data, 0);
            end else begin
                tick();
                aborted = 1'b1;
            end
        end
        if (aborted) begin
            for (int c = 0; c < RC; c++) begin
                check("abort_err_pulse", timeout_err, (c == 0));
                check("abort_rx_rst", rx_rst, 1);
                check("abort_gnt_clear", gnt, 0);
                check("abort_busy", busy, 1);
                check("abort_no_done", frame_done, 0);
                check("abort_rx_data", rx_data, 0);
                rx_rdy = 1'b1;
                tick();
            end
            check("post_abort_rx_rst", rx_rst, 0);
            check("post_abort_idle", busy, 0);
            check("post_abort_err", timeout_err, 0);
            check("post_abort_cur_port", cur_port, exp_port);
        end
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "time limit reached");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        req       = '0;
        rx_rdy    = 1'b0;
        port_data = '0;

        tbl[0] = '{4'b0100, 32'h44332211, 2, 8'h33};
        tbl[1] = '{4'b1111, 32'hA1B2C3D4, 3, 8'hA1};
        tbl[2] = '{4'b0011, 32'h0F1E2D3C, 0, 8'h3C};
        tbl[3] = '{4'b0001, 32'h55AA55AA, 0, 8'hAA};
        tbl[4] = '{4'b1000, 32'hDEADBEEF, 3, 8'hDE};
        tbl[5] = '{4'b1001, 32'h12345678, 0, 8'h78};
        tbl[6] = '{4'b0110, 32'h9ABCDEF0, 1, 8'hDE};
        tbl[7] = '{4'b0101, 32'hCAFEF00D, 2, 8'hFE};
        tbl[8] = '{4'b0011, 32'h01020304, 0, 8'h04};
        tbl[9] = '{4'b1110, 32'h7F00FF80, 1, 8'hFF};
        fair_exp = '{0, 1, 2, 3, 0};

        // Reset values
        #1 rst = 1'b1;
        #2;
        check("reset_gnt", gnt, 0);
        check("reset_rx_start", rx_start, 0);
        check("reset_rx_rst", rx_rst, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_timeout_err", timeout_err, 0);
        check("reset_cur_port", cur_port, NP - 1);
        check("reset_rx_data", rx_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_cur = NP - 1;

        // Fairness: all ports requesting, five back-to-back frames
        port_data = 32'hD3C2B1A0;
        for (int f = 0; f < 5; f++) begin
            do_frame(4'hF, K_NORMAL, 3, fair_exp[f], slice(fair_exp[f]), 1'b0);
        end
        m_cur = 0;

        // Arbitration vector table
        for (int i = 0; i < 10; i++) begin
            port_data = tbl[i].pdata;
            do_frame(tbl[i].req, K_NORMAL, 2, tbl[i].exp_port, tbl[i].exp_data, 1'b0);
        end
        m_cur = 1;

        // Single frame on port 2, watchdog abort, rejected start, tie of rx_rdy and watchdog
        port_data = 32'h8C7B6A59;
        do_frame(4'b0100, K_NORMAL, 12, 2, slice(2), 1'b0);
        do_frame(4'b0010, K_TIMEOUT, 0, 1, slice(1), 1'b0);
        do_frame(4'b1111, K_NORMAL, 1, 2, slice(2), 1'b0);
        do_frame(4'b1000, K_REJECT, 0, 3, slice(3), 1'b0);
        do_frame(4'b1111, K_NORMAL, 1, 0, slice(0), 1'b0);
        do_frame(4'b0100, K_NORMAL, TO, 2, slice(2), 1'b0);

        // Blocked arbitration while the receiver is not ready
        rx_rdy = 1'b0;
        req    = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("blocked_no_gnt", gnt, 0);
            check("blocked_idle", busy, 0);
            check("blocked_no_start", rx_start, 0);
        end
        rx_rdy = 1'b1;
        tick();
        check("unblock_gnt", gnt, 4'b0001);
        check("unblock_start", rx_start, 1);
        check("unblock_cur_port", cur_port, 0);

        // Asynchronous reset in the middle of a frame
        rx_rdy = 1'b0;
        tick();
        tick();
        tick();
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midreset_gnt", gnt, 0);
        check("midreset_busy", busy, 0);
        check("midreset_cur_port", cur_port, NP - 1);
        check("midreset_rx_rst", rx_rst, 0);
        check("midreset_rx_start", rx_start, 0);
        check("midreset_rx_data", rx_data, 0);
        req    = 4'hF;
        rx_rdy = 1'b1;
        tick();
        check("reset_held_idle", busy, 0);
        rst = 1'b0;
        do_frame(4'hF, K_NORMAL, 2, 0, slice(0), 1'b0);
        m_cur = 0;

        // Randomized frames against the round-robin model
        for (int t = 0; t < 40; t++) begin
            r_rand    = NP'($urandom_range(1, (1 << NP) - 1));
            roll      = int'($urandom_range(0, 9));
            kind      = (roll < 7) ? K_NORMAL : ((roll < 9) ? K_TIMEOUT : K_REJECT);
            len       = int'($urandom_range(1, TO));
            port_data = $urandom;
            p         = predict(r_rand, m_cur);
            do_frame(r_rand, kind, len, p, slice(p), 1'b1);
            m_cur     = p;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
